// File: rtl/xor_share_sched_if.sv
// Request/grant/result bundle between two requesters and xor_share_sched.
// master = requester side, slave = scheduler side.
interface xor_share_sched_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] result;
    logic             parity;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  gnt0, gnt1, busy, done, done_id, result, parity
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output gnt0, gnt1, busy, done, done_id, result, parity
    );
endinterface

// File: rtl/xor_share_sched.sv
// Round-robin scheduler streaming two requesters' operands LSB-first through one 1-bit XOR cell.
// Optional running-parity cell enabled by defining XOR_SHARE_SCHED_PARITY_EN.
module xor_share_sched #(
    parameter int unsigned WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    xor_share_sched_if.slave  bus
);
    localparam int unsigned IdxW = $clog2(WIDTH);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StGrant, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              last_q, last_d;
    logic              id_q, id_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              done_id_q, done_id_d;
    logic              sel;
    logic              xor_bit;
    logic              gnt0, gnt1, done;

    // The single shared XOR cell.
    assign xor_bit = a_sh_q[0] ^ b_sh_q[0];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        id_d      = id_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        result_d  = result_q;
        done_id_d = done_id_q;
        sel       = 1'b0;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    sel     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    id_d    = sel;
                    a_sh_d  = sel ? bus.a1 : bus.a0;
                    b_sh_d  = sel ? bus.b1 : bus.b0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                gnt0    = ~id_q;
                gnt1    = id_q;
                last_d  = id_q;
                idx_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                // Result bits enter the vacated top of the A register, so after WIDTH shifts
                // the A register holds the full result.
                a_sh_d = {xor_bit, a_sh_q[WIDTH-1:1]};
                b_sh_d = b_sh_q >> 1;
                idx_d  = idx_q + 1'b1;
                if (idx_q == IdxLast) begin
                    result_d  = a_sh_d;
                    done_id_d = id_q;
                    state_d   = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            last_q    <= 1'b1;
            id_q      <= 1'b0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            result_q  <= '0;
            done_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            id_q      <= id_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            result_q  <= result_d;
            done_id_q <= done_id_d;
        end
    end

`ifdef XOR_SHARE_SCHED_PARITY_EN
    logic par_acc_q, par_acc_d;
    logic parity_q, parity_d;

    always_comb begin
        par_acc_d = par_acc_q;
        parity_d  = parity_q;
        if (state_q == StGrant) begin
            par_acc_d = 1'b0;
        end else if (state_q == StRun) begin
            par_acc_d = par_acc_q ^ xor_bit;
            if (idx_q == IdxLast) begin
                parity_d = par_acc_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_acc_q <= 1'b0;
            parity_q  <= 1'b0;
        end else begin
            par_acc_q <= par_acc_d;
            parity_q  <= parity_d;
        end
    end

    assign bus.parity = parity_q;
`else
    assign bus.parity = 1'b0;
`endif

    assign bus.gnt0    = gnt0;
    assign bus.gnt1    = gnt1;
    assign bus.done    = done;
    assign bus.busy    = (state_q != StIdle);
    assign bus.done_id = done_id_q;
    assign bus.result  = result_q;
endmodule

// File: tb/tb_xor_share_sched.sv
// Directed self-checking bench for xor_share_sched (WIDTH = 8); parity expectations follow
// XOR_SHARE_SCHED_PARITY_EN.
module tb_xor_share_sched;
    localparam int unsigned WIDTH = 8;
`ifdef XOR_SHARE_SCHED_PARITY_EN
    localparam logic ParOn = 1'b1;
`else
    localparam logic ParOn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    xor_share_sched_if #(.WIDTH(WIDTH)) bus ();

    xor_share_sched #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until done (99 on timeout).
    task automatic wait_done(output int n);
        n = 99;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Returns edges until a grant (99 on timeout) and which requester got it.
    task automatic wait_gnt(output int n, output logic id);
        n  = 99;
        id = 1'bx;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if ((bus.gnt0 | bus.gnt1) === 1'b1) begin
                n  = i;
                id = bus.gnt1;
                break;
            end
        end
    endtask

    initial begin
        int   n;
        int   n2;
        logic id;

        // Reset with both requests high
        rst = 1'b1;
        bus.req0 = 1'b1; bus.a0 = 8'hA5; bus.b0 = 8'h0F;
        bus.req1 = 1'b1; bus.a1 = 8'h00; bus.b1 = 8'h00;
        repeat (2) tick();
        chk("rst_gnt0", bus.gnt0, 0);
        chk("rst_gnt1", bus.gnt1, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_done_id", bus.done_id, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_parity", bus.parity, 0);

        // First grant after reset goes to requester 0; single operation A5 ^ 0F
        rst = 1'b0;
        wait_gnt(n, id);
        chk("first_gnt_lat", n, 1);
        chk("first_gnt_id", id, 0);
        chk("first_gnt1_low", bus.gnt1, 0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk("busy_in_grant", bus.busy, 1);
        wait_done(n);
        chk("single_done_lat", n, 9);
        chk("single_result", bus.result, 8'hAA);
        chk("single_done_id", bus.done_id, 0);
        chk("single_parity", bus.parity, 0);
        tick();
        chk("single_done_pulse", bus.done, 0);
        chk("single_idle_busy", bus.busy, 0);
        chk("single_result_hold", bus.result, 8'hAA);

        // Asynchronous reset clears the held result immediately
        rst = 1'b1;
        #1;
        chk("async_rst_result", bus.result, 0);
        tick();
        rst = 1'b0;

        // Simultaneous requests: requester 0 first, then 1, dones 11 clocks apart
        bus.a0 = 8'hFF; bus.b0 = 8'h00; bus.req0 = 1'b1;
        bus.a1 = 8'h81; bus.b1 = 8'h01; bus.req1 = 1'b1;
        wait_gnt(n, id);
        chk("sim_gnt_first", id, 0);
        bus.req0 = 1'b0;
        wait_done(n);
        chk("sim_done1_lat", n, 9);
        chk("sim_result1", bus.result, 8'hFF);
        chk("sim_done_id1", bus.done_id, 0);
        chk("sim_parity1", bus.parity, 0);
        wait_gnt(n, id);
        chk("sim_gnt_second", id, 1);
        bus.req1 = 1'b0;
        wait_done(n2);
        chk("sim_done_spacing", n + n2, 11);
        chk("sim_result2", bus.result, 8'h80);
        chk("sim_done_id2", bus.done_id, 1);
        chk("sim_parity2", bus.parity, ParOn);

        // Fairness: both held for four operations
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(n, id);
            chk("fair_gnt_order", id, k % 2);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        wait_done(n);
        chk("fair_done_lat", n, 9);
        chk("fair_result", bus.result, 8'h80);
        chk("fair_done_id", bus.done_id, 1);

        // Reset during the fourth RUN cycle aborts without done
        bus.a0 = 8'hA5; bus.b0 = 8'h0F; bus.req0 = 1'b1;
        wait_gnt(n, id);
        chk("abort_gnt_id", id, 0);
        bus.req0 = 1'b0;
        repeat (4) tick();
        chk("abort_busy_run", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_result", bus.result, 0);
        tick();
        rst = 1'b0;

        // Requester 1 after the abort completes normally
        bus.a1 = 8'h0F; bus.b1 = 8'hF0; bus.req1 = 1'b1;
        wait_gnt(n, id);
        chk("post_abort_gnt_lat", n, 1);
        chk("post_abort_gnt_id", id, 1);
        bus.req1 = 1'b0;
        wait_done(n);
        chk("post_abort_done_lat", n, 9);
        chk("post_abort_result", bus.result, 8'hFF);
        chk("post_abort_done_id", bus.done_id, 1);
        chk("post_abort_parity", bus.parity, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/xor_share_sched.md
Name: xor_share_sched

Overview:
- Scheduler that time-shares one 1-bit gate-level XOR cell between two requesters.
- Each requester submits a WIDTH-bit operand pair. The block arbitrates round-robin, then streams the pair LSB-first through the single XOR cell, one bit per clock.
- It returns the WIDTH-bit XOR result with a done pulse and requester ID.
- It sits between lab-level requester logic, such as switch/button front ends, and the shared bitwise datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 request; held high until gnt0.
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- req1  input  1  requester 1 request; held high until gnt1.
- a1  input  WIDTH  requester 1 operand A.
- b1  input  WIDTH  requester 1 operand B.
- gnt0  output  1  one-cycle grant pulse to requester 0.
- gnt1  output  1  one-cycle grant pulse to requester 1.
- busy  output  1  high while in any state other than IDLE.
- done  output  1  one-cycle pulse; result is valid.
- done_id  output  1  requester served by the last completed operation.
- result  output  WIDTH  a XOR b of the last completed operation.
- parity  output  1  XOR-reduction of result (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high), effective immediately:
  - State = IDLE; bit index = 0; round-robin pointer last = 1, so requester 0 has first priority.
  - gnt0, gnt1, busy, done, done_id, result and parity are all 0.
- FSM states: IDLE, GRANT, RUN, DONE.
- IDLE:
  - Request inputs are sampled only in IDLE.
  - Only one request high: grant that requester.
  - Both high: grant the requester other than last.
  - On the granting edge: latch the selected a/b into internal shift registers, record the ID, go to GRANT.
  - No request: stay in IDLE.
- GRANT: one cycle with the matching gntX = 1; last <= granted ID; bit index = 0; next state RUN.
- RUN: exactly WIDTH cycles.
  - Cycle i feeds operand bits a[i] and b[i] into the single XOR cell.
  - The cell output is shifted into the result accumulator, LSB first.
  - The bit index increments; when the index equals WIDTH-1, the next state is DONE.
- DONE: one cycle.
  - done = 1; result, done_id and parity take their new values in this cycle.
  - Next state is IDLE.
- Latency:
  - The sampling edge in IDLE is E0. gnt is high after E0; RUN spans the cycles after E1..E_WIDTH; done is high after E(WIDTH+1).
  - Request-to-done is WIDTH+1 clocks; back-to-back throughput is one operation per WIDTH+3 clocks.
- Holding registers: result, done_id and parity hold their values from one DONE cycle until the next DONE; they change at no other time except reset.
- Input changes:
  - Changes on a/b/req during GRANT, RUN or DONE are ignored; operands were latched at E0.
  - A requester that drops req before its grant is simply not served.
- Reset mid-operation:
  - Aborts immediately with no done pulse; all outputs return to reset values.
  - A previously held result is cleared to 0.
- Width rules:
  - The bit index counter is sized to hold WIDTH-1.
  - The result register is exactly WIDTH bits.
  - No arithmetic carries are involved.

Optional Feature:
- Macro: XOR_SHARE_SCHED_PARITY_EN.
- Defined:
  - A second 1-bit XOR cell accumulates running parity during RUN; the accumulator is cleared in GRANT.
  - parity is updated in DONE to the XOR-reduction of the new result.
- Undefined: the second cell and accumulator are absent; parity is tied to constant 0.
- Port list is identical in both cases.

Test Plan:
- Reset: rst = 1 for 2 clocks with req0 = req1 = 1 -> all outputs 0, no gnt, busy = 0. Deassert rst -> gnt0 is the first grant.
- Single requester, WIDTH = 8: req0 with a0 = 8'hA5, b0 = 8'h0F -> gnt0 one cycle after the sampling edge, done 9 clocks after it, result = 8'hAA, done_id = 0, parity = 0 (macro on).
- Simultaneous: req0 (a0 = 8'hFF, b0 = 8'h00) and req1 (a1 = 8'h81, b1 = 8'h01) at the same edge -> first done: result 8'hFF, done_id 0. Second done: result 8'h80, done_id 1, parity 1 (macro on). The two done pulses are 11 clocks apart.
- Fairness: req0 and req1 held high for 4 operations -> grant order 0, 1, 0, 1; never two consecutive grants to the same requester.
- Reset mid-RUN: rst pulsed during the 4th RUN cycle -> no done; result = 0, busy = 0. A following req1 with a1 = 8'h0F, b1 = 8'hF0 completes normally: result 8'hFF, done_id 1.
- Macro off: repeat the single-requester scenario -> result 8'hAA and parity stays 0 throughout.
